oven_cook_timer: RTL
====================

Name: oven_cook_timer

Overview:
Cook-time countdown for the oven, the down-counting counterpart of the time-of-day clock. The user loads a cook time as MM:SS in BCD with +1 min and +10 s button pulses. The block counts down to 00:00 at 1 Hz, enables the heater while running, then raises a timed done alarm. It drives four 7-segment digits in the same active-low [0:6] format the clock display uses.

Parameters:
TICK_DIV, 50000000, clk cycles per 1 s tick (4 in simulation)
ALARM_SECS, 5, seconds done_alarm stays high before auto-return to IDLE

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
add_min  in  1  1-cycle pulse, add 1 minute (already debounced/synchronized upstream)
add_10s  in  1  1-cycle pulse, add 10 seconds
start  in  1  1-cycle pulse, start/resume
stop  in  1  1-cycle pulse, pause/cancel/silence
sec_ones  out  4  BCD 0-9
sec_tens  out  4  BCD 0-5
min_ones  out  4  BCD 0-9
min_tens  out  4  BCD 0-9
heater_on  out  1  high only in RUN
paused  out  1  high only in PAUSE
done_alarm  out  1  high only in DONE
Hex0, Hex1, Hex2, Hex3  out  7 each [0:6]  active-low segments a..g (index 0 = a); Hex0 = sec_ones ... Hex3 = min_tens

Behaviour:
- Reset, evaluated at the clk edge and dominant over all inputs: state IDLE, all digits 0, prescaler 0, alarm counter 0, heater_on/paused/done_alarm 0. Hex0-3 show "0" = 0000001.
- All outputs are registered or decoded from registers. The hex decode is combinational from the digit registers. Digits 10-15 are never reachable; if decoded anyway, they show blank (1111111).
- Prescaler: counts 0..TICK_DIV-1 in RUN and DONE, and holds in IDLE and PAUSE. tick = 1 when prescaler == TICK_DIV-1, then the prescaler wraps to 0. The prescaler is cleared on every entry to RUN or DONE, so the first decrement lands exactly TICK_DIV cycles after the start pulse edge.
- Input priority within one cycle: stop > start > add_min/add_10s.
- States and transitions:
  - IDLE: start with time != 00:00 -> RUN. start with time 00:00 is ignored. stop clears digits to 00:00.
  - RUN: tick decrements 1 s with BCD borrow (sec_ones 0->9 borrows sec_tens; sec_tens 0->5 borrows min_ones; min_ones 0->9 borrows min_tens). Decrementing from 00:01 goes to 00:00 and enters DONE in the same edge. stop -> PAUSE with digits held. start has no effect.
  - PAUSE: start -> RUN. stop -> IDLE with digits cleared to 00:00.
  - DONE: digits are 00:00. After ALARM_SECS ticks -> IDLE. stop -> IDLE immediately. start and adds are ignored.
- Adds are accepted in IDLE, RUN and PAUSE.
  - add_min: minutes +1 with BCD carry. If minutes == 99, nothing changes.
  - add_10s: sec_tens +1; at 5 it wraps to 0 and carries into minutes. If the result would exceed 99:59, it saturates at 99:59.
  - add_min and add_10s together: apply both, minute first, then saturate.
- In RUN, an add pulse in the same cycle as a tick is dropped. The decrement takes effect.
- Reset mid-RUN or mid-DONE returns to IDLE at 00:00 on that edge, with heater_on and done_alarm 0 on the next cycle.

Test Plan:
- Reset then idle: reset=1 for 2 cycles -> digits 0000, Hex0-3 = 0000001, heater_on=0, done_alarm=0. start with 00:00 -> remains IDLE.
- Load and BCD carry (TICK_DIV=4): 7x add_10s -> 01:10. add_min -> 02:10. Press add_min 99 times -> 99:10; then add_10s x6 -> 99:59 saturated.
- Countdown with borrow: load 01:00, start -> exactly 4 cycles later 00:59 with heater_on=1. Continue to 00:00 -> done_alarm=1, heater_on=0. Exactly 5 ticks (20 cycles) later -> IDLE, done_alarm=0.
- Pause/resume/cancel: RUN at 00:45, stop -> paused=1 and digits frozen for 50 cycles. start -> decrement 4 cycles later to 00:44. stop, stop -> IDLE at 00:00.
- Priority: start and stop in the same cycle in PAUSE -> IDLE at 00:00. add_10s coinciding with a tick in RUN at 00:30 -> 00:29 (add dropped).
- Reset mid-operation: RUN at 00:20, reset=1 for 1 cycle -> next cycle digits 0000 and heater_on=0. In DONE, stop -> done_alarm=0 next cycle.

Source files
------------

// File: rtl/oven_cook_timer.sv
// Cook-time countdown: BCD MM:SS loaded by +1 min / +10 s buttons,
// counted down at 1 Hz with the heater on, then a timed done alarm.
module oven_cook_timer #(
   parameter int unsigned TICK_DIV   = 50000000,
   parameter int unsigned ALARM_SECS = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       add_min,
   input  logic       add_10s,
   input  logic       start,
   input  logic       stop,
   output logic [3:0] sec_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] min_ones,
   output logic [3:0] min_tens,
   output logic       heater_on,
   output logic       paused,
   output logic       done_alarm,
   output logic [0:6] Hex0,
   output logic [0:6] Hex1,
   output logic [0:6] Hex2,
   output logic [0:6] Hex3
);

   localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned AW = (ALARM_SECS > 1) ? $clog2(ALARM_SECS) : 1;

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

   state_t        state, state_n;
   logic [PW-1:0] presc, presc_n;
   logic [AW-1:0] acnt, acnt_n;
   logic [15:0]   cur, cur_n, add_t, dec_t;
   logic [7:0]    add_m;
   logic [3:0]    a_st, a_so;
   logic [3:0]    d_so, d_st, d_mo, d_mt;
   logic          b0, b1, b2;
   logic          tick, is_zero, is_one, any_add;

   // Minutes +1 with BCD carry; holds at 99.
   function automatic logic [7:0] inc_min(input logic [7:0] m);
      if (m == 8'h99)
         return m;
      else if (m[3:0] == 4'd9)
         return {m[7:4] + 4'd1, 4'd0};
      else
         return {m[7:4], m[3:0] + 4'd1};
   endfunction

   // Active-low a..g segment pattern, index 0 = a; 10-15 blank.
   function automatic logic [0:6] seg7(input logic [3:0] d);
      case (d)
         4'd0:    return 7'b0000001;
         4'd1:    return 7'b1001111;
         4'd2:    return 7'b0010010;
         4'd3:    return 7'b0000110;
         4'd4:    return 7'b1001100;
         4'd5:    return 7'b0100100;
         4'd6:    return 7'b0100000;
         4'd7:    return 7'b0001111;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0000100;
         default: return 7'b1111111;
      endcase
   endfunction

   assign cur     = {min_tens, min_ones, sec_tens, sec_ones};
   assign is_zero = (cur == 16'h0000);
   assign is_one  = (cur == 16'h0001);
   assign any_add = add_min | add_10s;
   assign tick    = ((state == RUN) || (state == DONE)) && (presc == PW'(TICK_DIV - 1));

   assign heater_on  = (state == RUN);
   assign paused     = (state == PAUSE);
   assign done_alarm = (state == DONE);

   assign Hex0 = seg7(sec_ones);
   assign Hex1 = seg7(sec_tens);
   assign Hex2 = seg7(min_ones);
   assign Hex3 = seg7(min_tens);

   // Button arithmetic: minute increment first, then +10 s with carry and 99:59 saturation.
   always_comb begin
      add_m = {min_tens, min_ones};
      a_st  = sec_tens;
      a_so  = sec_ones;
      if (add_min)
         add_m = inc_min(add_m);
      if (add_10s) begin
         if (sec_tens == 4'd5) begin
            if (add_m == 8'h99) begin
               a_st = 4'd5;
               a_so = 4'd9;
            end else begin
               a_st  = 4'd0;
               add_m = inc_min(add_m);
            end
         end else begin
            a_st = sec_tens + 4'd1;
         end
      end
      add_t = {add_m, a_st, a_so};
   end

   // One-second BCD decrement with borrow chain through all four digits.
   always_comb begin
      b0   = (sec_ones == 4'd0);
      d_so = b0 ? 4'd9 : sec_ones - 4'd1;
      b1   = b0 && (sec_tens == 4'd0);
      d_st = b0 ? ((sec_tens == 4'd0) ? 4'd5 : sec_tens - 4'd1) : sec_tens;
      b2   = b1 && (min_ones == 4'd0);
      d_mo = b1 ? ((min_ones == 4'd0) ? 4'd9 : min_ones - 4'd1) : min_ones;
      d_mt = b2 ? min_tens - 4'd1 : min_tens;
      dec_t = {d_mt, d_mo, d_st, d_so};
   end

   // Next-state, digit, prescaler and alarm-counter logic; stop > start > adds.
   always_comb begin
      state_n = state;
      cur_n   = cur;
      acnt_n  = acnt;
      presc_n = presc;
      if ((state == RUN) || (state == DONE))
         presc_n = tick ? '0 : presc + PW'(1);
      unique case (state)
         IDLE: begin
            if (stop) begin
               cur_n = '0;
            end else if (start && !is_zero) begin
               state_n = RUN;
               presc_n = '0;
            end else if (any_add) begin
               cur_n = add_t;
            end
         end
         RUN: begin
            if (stop) begin
               state_n = PAUSE;
            end else if (tick) begin
               // A tick wins over a same-cycle add; reaching 00:00 enters DONE on this edge.
               cur_n = dec_t;
               if (is_one) begin
                  state_n = DONE;
                  presc_n = '0;
                  acnt_n  = '0;
               end
            end else if (any_add) begin
               cur_n = add_t;
            end
         end
         PAUSE: begin
            if (stop) begin
               state_n = IDLE;
               cur_n   = '0;
            end else if (start) begin
               state_n = RUN;
               presc_n = '0;
            end else if (any_add) begin
               cur_n = add_t;
            end
         end
         DONE: begin
            cur_n = '0;
            if (stop) begin
               state_n = IDLE;
            end else if (tick) begin
               if (acnt == AW'(ALARM_SECS - 1))
                  state_n = IDLE;
               else
                  acnt_n = acnt + AW'(1);
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         presc    <= '0;
         acnt     <= '0;
         min_tens <= '0;
         min_ones <= '0;
         sec_tens <= '0;
         sec_ones <= '0;
      end else begin
         state    <= state_n;
         presc    <= presc_n;
         acnt     <= acnt_n;
         min_tens <= cur_n[15:12];
         min_ones <= cur_n[11:8];
         sec_tens <= cur_n[7:4];
         sec_ones <= cur_n[3:0];
      end
   end

endmodule
